// File: rtl/npu_accum_requant_if.sv
// npu_accum_requant_if: partial-sum, config and result bus of the NPU accumulate/requantise stage
// master drives psums/config/flush and receives data/valid/busy; slave is the requant block.
interface npu_accum_requant_if #(
  parameter int CH_NUM      = 18,
  parameter int PSUM_WIDTH  = 24,
  parameter int BIAS_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int SCALE_WIDTH = 5,
  parameter int PASS_WIDTH  = 8
);
  logic [CH_NUM*PSUM_WIDTH-1:0] psum_in;
  logic                         psum_valid_in;
  logic [PASS_WIDTH-1:0]        pass_num_in;
  logic [CH_NUM*BIAS_WIDTH-1:0] bias_in;
  logic [SCALE_WIDTH-1:0]       scale_in;
  logic                         round_en_in;
  logic                         relu_en_in;
  logic                         flush_in;
  logic [CH_NUM*DATA_WIDTH-1:0] data_out;
  logic                         data_valid_out;
  logic                         busy_out;
  modport master (
    output psum_in, psum_valid_in, pass_num_in, bias_in, scale_in, round_en_in, relu_en_in, flush_in,
    input  data_out, data_valid_out, busy_out
  );
  modport slave (
    input  psum_in, psum_valid_in, pass_num_in, bias_in, scale_in, round_en_in, relu_en_in, flush_in,
    output data_out, data_valid_out, busy_out
  );
endinterface

// File: rtl/npu_accum_requant.sv
// npu_accum_requant: multi-pass per-channel accumulation followed by bias/shift/round/relu/saturate requantisation
// clk, rstn (async active-low); bus: npu_accum_requant_if.slave carrying psums, config, flush and results.
module npu_accum_requant #(
  parameter int CH_NUM      = 18,
  parameter int PSUM_WIDTH  = 24,
  parameter int ACC_WIDTH   = 32,
  parameter int BIAS_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int SCALE_WIDTH = 5,
  parameter int PASS_WIDTH  = 8
) (
  input logic                clk,
  input logic                rstn,
  npu_accum_requant_if.slave bus
);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((1 <<< (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX - (ACC_WIDTH+1)'(1);
  typedef enum logic {IDLE, ACCUM} state_e;
  state_e                         state_q, state_d;
  logic [PASS_WIDTH-1:0]          cnt_q, cnt_d, pass_q, pass_d, pass_eff;
  logic [SCALE_WIDTH-1:0]         scale_q, scale_d, scale_eff;
  logic                           round_q, round_d, round_eff;
  logic                           relu_q, relu_d, relu_eff;
  logic                           first, abort, take, last;
  logic signed [ACC_WIDTH-1:0]    acc_q [CH_NUM];
  logic signed [ACC_WIDTH-1:0]    acc_d [CH_NUM];
  logic signed [ACC_WIDTH-1:0]    sum [CH_NUM];
  logic                           v1_q, rnd1_q, relu1_q;
  logic [SCALE_WIDTH-1:0]         sc1_q;
  logic signed [ACC_WIDTH-1:0]    fin_q [CH_NUM];
  logic signed [ACC_WIDTH:0]      rnd;
  logic signed [ACC_WIDTH:0]      sh_d [CH_NUM];
  logic                           v2_q, relu2_q;
  logic signed [ACC_WIDTH:0]      s_q [CH_NUM];
  logic signed [ACC_WIDTH:0]      pos [CH_NUM];
  logic [CH_NUM*DATA_WIDTH-1:0]   clip_d, dout_q;
  logic                           valid_q;
  // Beats in IDLE open a group and use the live config; flush only aborts a group in progress.
  always_comb begin
    first     = state_q == IDLE;
    abort     = bus.flush_in && !first;
    take      = bus.psum_valid_in && !abort;
    pass_eff  = first ? (bus.pass_num_in == '0 ? PASS_WIDTH'(1) : bus.pass_num_in) : pass_q;
    scale_eff = first ? bus.scale_in : scale_q;
    round_eff = first ? bus.round_en_in : round_q;
    relu_eff  = first ? bus.relu_en_in : relu_q;
    last      = take && (cnt_q + PASS_WIDTH'(1) == pass_eff);
    for (int c = 0; c < CH_NUM; c++)
      sum[c] = (first ? ACC_WIDTH'($signed(bus.bias_in[c*BIAS_WIDTH +: BIAS_WIDTH])) : acc_q[c])
             + ACC_WIDTH'($signed(bus.psum_in[c*PSUM_WIDTH +: PSUM_WIDTH]));
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pass_d  = pass_q;
    scale_d = scale_q;
    round_d = round_q;
    relu_d  = relu_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '{default: '0};
    end else if (take) begin
      pass_d  = pass_eff;
      scale_d = scale_eff;
      round_d = round_eff;
      relu_d  = relu_eff;
      state_d = last ? IDLE : ACCUM;
      cnt_d   = last ? '0 : cnt_q + PASS_WIDTH'(1);
      for (int c = 0; c < CH_NUM; c++) acc_d[c] = last ? '0 : sum[c];
    end
  end
  // Scale and clip operate in ACC_WIDTH+1 bits so the rounding add cannot overflow.
  always_comb begin
    rnd    = (rnd1_q && sc1_q != '0) ? (ACC_WIDTH+1)'(1) << (sc1_q - SCALE_WIDTH'(1)) : '0;
    sh_d   = '{default: '0};
    pos    = '{default: '0};
    clip_d = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      sh_d[c] = ($signed({fin_q[c][ACC_WIDTH-1], fin_q[c]}) + rnd) >>> sc1_q;
      pos[c]  = (relu2_q && s_q[c] < 0) ? '0 : s_q[c];
      clip_d[c*DATA_WIDTH +: DATA_WIDTH] = pos[c] > SAT_MAX ? SAT_MAX[DATA_WIDTH-1:0]
                                         : pos[c] < SAT_MIN ? SAT_MIN[DATA_WIDTH-1:0]
                                         : pos[c][DATA_WIDTH-1:0];
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= '0;
      scale_q <= '0;
      round_q <= 1'b0;
      relu_q  <= 1'b0;
      v1_q    <= 1'b0;
      sc1_q   <= '0;
      rnd1_q  <= 1'b0;
      relu1_q <= 1'b0;
      v2_q    <= 1'b0;
      relu2_q <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        acc_q[c] <= '0;
        fin_q[c] <= '0;
        s_q[c]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      scale_q <= scale_d;
      round_q <= round_d;
      relu_q  <= relu_d;
      acc_q   <= acc_d;
      v1_q    <= last;
      if (last) begin
        fin_q   <= sum;
        sc1_q   <= scale_eff;
        rnd1_q  <= round_eff;
        relu1_q <= relu_eff;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        s_q     <= sh_d;
        relu2_q <= relu1_q;
      end
      valid_q <= v2_q;
      if (v2_q) dout_q <= clip_d;
    end
  end
  assign bus.data_out       = dout_q;
  assign bus.data_valid_out = valid_q;
  assign bus.busy_out       = state_q == ACCUM;
endmodule
